// File: rtl/neuron_feeder.sv
// Input-vector buffer and weight/bias store that streams (sample, weight)
// pairs into a neuron, one pair per clock, after a start request.
module neuron_feeder #(
  parameter int N_INPUTS = 16,
  parameter int DATA_W   = 16,
  parameter int IDX_W    = $clog2(N_INPUTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              w_wr_en,
  input  logic [IDX_W-1:0]  w_wr_addr,
  input  logic [DATA_W-1:0] w_wr_data,
  input  logic              bias_wr_en,
  input  logic [DATA_W-1:0] bias_wr_data,
  input  logic              start,
  output logic [DATA_W-1:0] inp_data,
  output logic [DATA_W-1:0] weight,
  output logic [DATA_W-1:0] bias,
  output logic              inp_ready,
  output logic              last,
  output logic              busy,
  output logic              done
);

  // FINISH is the cycle holding the last pair; done/in_ready follow it.
  typedef enum logic [1:0] {LOAD, FULL, STREAM, FINISH} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  state_t           state, next_state;
  logic [IDX_W-1:0] count, idx;
  logic             accept, wr_allowed;
  logic [DATA_W-1:0] sample_mem [N_INPUTS];
  logic [DATA_W-1:0] wmem [N_INPUTS];

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      LOAD: begin
        accept = in_valid && in_ready;
        if (accept && count == LAST_IDX) next_state = FULL;
      end
      FULL:    if (start) next_state = STREAM;
      STREAM:  if (idx == LAST_IDX) next_state = FINISH;
      FINISH:  next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  assign wr_allowed = (state == LOAD) || (state == FULL);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LOAD;
      count     <= '0;
      idx       <= '0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      last      <= 1'b0;
      inp_ready <= 1'b0;
      inp_data  <= '0;
      weight    <= '0;
      bias      <= '0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state == LOAD);
      busy      <= (next_state != LOAD);
      done      <= (state == FINISH);
      inp_ready <= (state == STREAM);
      last      <= (state == STREAM) && (idx == LAST_IDX);
      inp_data  <= '0;
      weight    <= '0;
      if (state == STREAM) begin
        inp_data <= sample_mem[idx];
        weight   <= wmem[idx];
        idx      <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
      end
      if (accept) count <= (count == LAST_IDX) ? '0 : count + IDX_W'(1);
      if (bias_wr_en && wr_allowed) bias <= bias_wr_data;
    end
  end

  // Storage is deliberately left out of reset; weights survive a reset.
  always_ff @(posedge clk) begin
    if (reset && accept) sample_mem[count] <= in_data;
    if (reset && w_wr_en && wr_allowed) wmem[w_wr_addr] <= w_wr_data;
  end

endmodule

// File: tb/tb_neuron_feeder.sv
// Directed self-checking bench for neuron_feeder with N_INPUTS=4.
module tb_neuron_feeder;
  localparam int N = 4;
  localparam int DW = 16;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, w_wr_en, bias_wr_en, start;
  logic inp_ready, last, busy, done;
  logic [DW-1:0] in_data, w_wr_data, bias_wr_data, inp_data, weight, bias;
  logic [IW-1:0] w_wr_addr;

  int passed = 0;
  int total  = 0;

  neuron_feeder #(.N_INPUTS(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr),
    .w_wr_data(w_wr_data), .bias_wr_en(bias_wr_en), .bias_wr_data(bias_wr_data),
    .start(start), .inp_data(inp_data), .weight(weight), .bias(bias),
    .inp_ready(inp_ready), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_weight(input logic [IW-1:0] a, input logic [DW-1:0] d);
    w_wr_en = 1'b1; w_wr_addr = a; w_wr_data = d;
    tick();
    w_wr_en = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    total++;
    if ({in_ready, inp_ready, last, busy, done, inp_data, weight, bias} !== '0)
      $display("FAIL reset_outputs got ir=%b pr=%b l=%b b=%b d=%b x=%h w=%h bias=%h exp all 0",
               in_ready, inp_ready, last, busy, done, inp_data, weight, bias);
    else passed++;
    reset = 1'b1;
    tick();
    total++;
    if ({in_ready, busy} !== 2'b10)
      $display("FAIL reset_release got in_ready=%b busy=%b exp 1 0", in_ready, busy);
    else passed++;
  endtask

  task automatic test_basic_stream();
    logic [DW-1:0] ex [N] = '{16'h0180, 16'h00FF, 16'h0012, 16'h0000};
    logic [DW-1:0] ew [N] = '{16'hFE00, 16'hFFFF, 16'hFFFF, 16'h0100};
    for (int i = 0; i < N; i++) wr_weight(IW'(i), ew[i]);
    bias_wr_en = 1'b1; bias_wr_data = 16'h0080;
    tick();
    bias_wr_en = 1'b0;
    for (int i = 0; i < N; i++) push(ex[i]);
    total++;
    if ({busy, in_ready, bias} !== {2'b10, 16'h0080})
      $display("FAIL basic_full got busy=%b in_ready=%b bias=%h exp 1 0 0080", busy, in_ready, bias);
    else passed++;
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if ({busy, inp_ready} !== 2'b10)
      $display("FAIL basic_start_lat got busy=%b inp_ready=%b exp 1 0", busy, inp_ready);
    else passed++;
    for (int i = 0; i < N; i++) begin
      tick();
      total++;
      if ({inp_ready, last, done, inp_data, weight, bias} !== {1'b1, (i == N-1), 1'b0, ex[i], ew[i], 16'h0080})
        $display("FAIL basic_pair%0d got rdy=%b last=%b done=%b x=%h w=%h bias=%h exp 1 %b 0 %h %h 0080",
                 i, inp_ready, last, done, inp_data, weight, bias, (i == N-1), ex[i], ew[i]);
      else passed++;
    end
    tick();
    total++;
    if ({done, inp_ready, in_ready, busy, last, inp_data, weight} !== {5'b10100, 32'h0})
      $display("FAIL basic_done got done=%b rdy=%b in_ready=%b busy=%b last=%b x=%h w=%h exp 1 0 1 0 0 0 0",
               done, inp_ready, in_ready, busy, last, inp_data, weight);
    else passed++;
    tick();
    total++;
    if (done !== 1'b0) $display("FAIL basic_done_width got done=%b exp 0", done);
    else passed++;
  endtask

  task automatic test_start_in_load();
    push(16'h0001);
    push(16'h0002);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    total++;
    if ({in_ready, busy, inp_ready} !== 3'b100)
      $display("FAIL start_in_load got in_ready=%b busy=%b inp_ready=%b exp 1 0 0", in_ready, busy, inp_ready);
    else passed++;
    push(16'h0003);
    in_valid = 1'b1; in_data = 16'h0004; start = 1'b1;
    tick();
    in_valid = 1'b0; start = 1'b0;
    total++;
    if ({busy, in_ready} !== 2'b10)
      $display("FAIL load_to_full got busy=%b in_ready=%b exp 1 0", busy, in_ready);
    else passed++;
    tick();
    total++;
    if ({busy, inp_ready} !== 2'b10)
      $display("FAIL start_with_last got busy=%b inp_ready=%b exp 1 0", busy, inp_ready);
    else passed++;
  endtask

  task automatic test_write_during_stream();
    logic [DW-1:0] ex [N] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    logic [DW-1:0] ex2 [N] = '{16'h0100, 16'hFF00, 16'h7FFF, 16'h8000};
    logic [DW-1:0] ew [N] = '{16'hFE00, 16'hFFFF, 16'hFFFF, 16'h0100};
    start = 1'b1;
    tick();
    start = 1'b0;
    w_wr_en = 1'b1; w_wr_addr = 2'd1; w_wr_data = 16'h7F00;
    bias_wr_en = 1'b1; bias_wr_data = 16'h1234;
    for (int i = 0; i < N; i++) begin
      tick();
      total++;
      if ({inp_ready, inp_data, weight, bias} !== {1'b1, ex[i], ew[i], 16'h0080})
        $display("FAIL wrstream_pair%0d got rdy=%b x=%h w=%h bias=%h exp 1 %h %h 0080",
                 i, inp_ready, inp_data, weight, bias, ex[i], ew[i]);
      else passed++;
    end
    tick();
    w_wr_en = 1'b0; bias_wr_en = 1'b0;
    total++;
    if ({done, bias} !== {1'b1, 16'h0080})
      $display("FAIL wrstream_done got done=%b bias=%h exp 1 0080", done, bias);
    else passed++;
    for (int i = 0; i < N; i++) push(ex2[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      tick();
      total++;
      if ({inp_ready, inp_data, weight, bias} !== {1'b1, ex2[i], ew[i], 16'h0080})
        $display("FAIL second_vec_pair%0d got rdy=%b x=%h w=%h bias=%h exp 1 %h %h 0080",
                 i, inp_ready, inp_data, weight, bias, ex2[i], ew[i]);
      else passed++;
    end
    tick();
  endtask

  task automatic test_reset_mid_stream();
    bit saw_done = 1'b0;
    for (int i = 0; i < N; i++) push(16'h0010 + 16'(i));
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    total++;
    if ({inp_ready, busy, done, last, bias} !== '0)
      $display("FAIL midreset_abort got rdy=%b busy=%b done=%b last=%b bias=%h exp 0 0 0 0 0000",
               inp_ready, busy, done, last, bias);
    else passed++;
    reset = 1'b1;
    tick();
    total++;
    if ({in_ready, busy, bias} !== {2'b10, 16'h0000})
      $display("FAIL midreset_release got in_ready=%b busy=%b bias=%h exp 1 0 0000", in_ready, busy, bias);
    else passed++;
    for (int i = 0; i < 6; i++) begin
      if (done || inp_ready) saw_done = 1'b1;
      tick();
    end
    total++;
    if (saw_done !== 1'b0) $display("FAIL midreset_no_done got activity=%b exp 0", saw_done);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ea [N] = '{16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00};
    logic [DW-1:0] eb [N] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [DW-1:0] ew [N] = '{16'hFE00, 16'hFFFF, 16'hFFFF, 16'h0100};
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_data = ea[i];
      tick();
    end
    in_data = 16'hDEAD;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      tick();
      total++;
      if ({inp_ready, inp_data, weight, bias} !== {1'b1, ea[i], ew[i], 16'h0000})
        $display("FAIL held_valid_pair%0d got rdy=%b x=%h w=%h bias=%h exp 1 %h %h 0000",
                 i, inp_ready, inp_data, weight, bias, ea[i], ew[i]);
      else passed++;
    end
    in_data = eb[0];
    tick();
    total++;
    if ({done, in_ready} !== 2'b11)
      $display("FAIL held_valid_done got done=%b in_ready=%b exp 1 1", done, in_ready);
    else passed++;
    for (int i = 0; i < N; i++) begin
      in_data = eb[i];
      tick();
    end
    in_valid = 1'b0;
    total++;
    if ({busy, in_ready} !== 2'b10)
      $display("FAIL reload_full got busy=%b in_ready=%b exp 1 0", busy, in_ready);
    else passed++;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      tick();
      total++;
      if ({inp_ready, last, inp_data, weight} !== {1'b1, (i == N-1), eb[i], ew[i]})
        $display("FAIL reload_pair%0d got rdy=%b last=%b x=%h w=%h exp 1 %b %h %h",
                 i, inp_ready, last, inp_data, weight, (i == N-1), eb[i], ew[i]);
      else passed++;
    end
    tick();
    total++;
    if (done !== 1'b1) $display("FAIL reload_done got done=%b exp 1", done);
    else passed++;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; w_wr_en = 1'b0; w_wr_addr = '0;
    w_wr_data = '0; bias_wr_en = 1'b0; bias_wr_data = '0; start = 1'b0;
    test_reset();
    test_basic_stream();
    test_start_in_load();
    test_write_during_stream();
    test_reset_mid_stream();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/neuron_feeder.md
Name: neuron_feeder

Overview:
- Upstream stage of `neuron`. Buffers one input vector of N_INPUTS Q8.8 samples and holds a writable weight memory plus a bias register.
- On `start`, streams (input, weight) pairs to the neuron, one pair per clock, with `inp_ready` asserted.
- Directly drives the neuron's `inp_data`, `weight`, `bias` and `inp_ready` ports.

Parameters:
- N_INPUTS, 16, number of inputs/weights per neuron evaluation (≥2).
- DATA_W, 16, sample/weight/bias width, signed Q8.8.
- IDX_W, $clog2(N_INPUTS), index/address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  input-sample valid.
- in_data  in  DATA_W  input sample, signed Q8.8.
- in_ready  out  1  feeder can accept a sample this cycle.
- w_wr_en  in  1  weight memory write enable.
- w_wr_addr  in  IDX_W  weight write address.
- w_wr_data  in  DATA_W  weight, signed Q8.8.
- bias_wr_en  in  1  bias register write enable.
- bias_wr_data  in  DATA_W  bias, signed Q8.8.
- start  in  1  begin streaming the buffered vector.
- inp_data  out  DATA_W  sample to neuron.
- weight  out  DATA_W  weight to neuron.
- bias  out  DATA_W  current bias register.
- inp_ready  out  1  pair valid to neuron.
- last  out  1  high with the final pair of a vector.
- busy  out  1  high in FULL or STREAM.
- done  out  1  one-cycle pulse after the last pair.

Behaviour:
- All outputs are registered.
- Reset (reset==0 at a rising edge):
  - state=LOAD, load count=0, stream index=0.
  - in_ready=1 on the first cycle after reset deasserts.
  - inp_data=0, weight=0, inp_ready=0, last=0, busy=0, done=0, bias=0.
  - Weight memory contents are not reset.
  - Reset mid-STREAM aborts immediately; no done pulse is produced.
- LOAD:
  - in_ready=1.
  - A sample is accepted when in_valid && in_ready. It is stored at buffer[count] and count increments.
  - Accepting sample N_INPUTS-1 moves the state to FULL and drops in_ready on the next cycle.
  - start is ignored in LOAD.
- FULL:
  - in_ready=0, busy=1. Waits for start.
  - start sampled high at edge k → STREAM. First pair appears on the outputs after edge k+1.
- STREAM:
  - One pair per cycle for N_INPUTS consecutive cycles, in order i=0..N_INPUTS-1: inp_data=buffer[i], weight=wmem[i], inp_ready=1.
  - No backpressure and no bubbles.
  - last=1 only with i=N_INPUTS-1. start is ignored.
  - After the last pair: inp_ready=0, inp_data=0, weight=0, done=1 for exactly one cycle.
  - The state then returns to LOAD with count=0 and in_ready=1 in the same cycle as done.
- Outside STREAM, inp_data, weight and inp_ready are 0.
- Weight writes:
  - Accepted in LOAD and FULL.
  - Dropped during STREAM, so the weights stay stable for the whole vector.
  - A write and a stream read of the same address never coincide.
- Bias:
  - bias_wr_en updates `bias` on the next edge in any state except STREAM, where it is dropped.
  - `bias` is held constant on the output at all times.
- Simultaneous events:
  - The last sample accepted together with start in the same cycle: start is ignored, because start is only honoured in FULL.
  - in_valid while in_ready=0 is not consumed.

Test Plan:
- N_INPUTS=4, reset low 3 cycles then high → all outputs 0, in_ready=1 on the cycle after release, busy=0.
- Write wmem = {FE00, FFFF, FFFF, 0100}, bias=0080; push samples {0180, 00FF, 0012, 0000}; pulse start → four consecutive inp_ready=1 cycles with pairs (0180,FE00), (00FF,FFFF), (0012,FFFF), (0000,0100); last only on the 4th; done one cycle later; bias=0080 throughout.
- Pulse start during LOAD after 2 samples → no streaming; in_ready stays 1; after 2 more samples busy=1 and in_ready=0.
- w_wr_en to addr 1 with 7F00 and bias_wr_en during STREAM → streamed weight[1] remains FFFF and bias unchanged; a second vector afterwards uses the old values.
- Assert reset on the 2nd STREAM cycle → next cycle inp_ready=0, busy=0, done never pulses, in_ready=1, bias=0.
- in_valid held high through FULL and STREAM → no extra samples stored; after done, a new vector of 4 loads correctly and streams in order.
